// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: widths, writeback-select and
// load-type encodings, and the MEM/WB stage register layout.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    // Writeback source select; 2'b11 is reserved and behaves as ALU.
    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_LOAD = 2'b01,
        WB_SEL_LINK = 2'b10
    } wb_sel_e;

    // Load types; unlisted encodings behave as a full-word load.
    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_H  = 3'b001,
        LD_HU = 3'b010,
        LD_B  = 3'b011,
        LD_BU = 3'b100
    } load_type_e;

    // MEM/WB stage register. reg_write already has the $0 and valid
    // qualification folded in, so it drives the write enable directly.
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [REG_AW-1:0] rd_addr;
        logic [DATA_W-1:0] wdata;
    } wb_stage_t;

    localparam wb_stage_t WB_STAGE_RESET = '{
        valid:     1'b0,
        reg_write: 1'b0,
        rd_addr:   5'd0,
        wdata:     32'd0
    };

endpackage

// File: rtl/mips_writeback_stage_if.sv
// MEM-to-WB bus: memory-stage result and pipeline control in, register
// file write port, forwarding source and retire counter out.
interface mips_writeback_stage_if;
    import mips_pkg::*;

    logic              stall;
    logic              flush;
    logic              in_valid;
    logic              in_reg_write;
    logic [REG_AW-1:0] in_rd_addr;
    logic [1:0]        in_wb_sel;
    logic [DATA_W-1:0] in_alu_result;
    logic [DATA_W-1:0] in_mem_rdata;
    logic [DATA_W-1:0] in_link_addr;
    logic [2:0]        in_load_type;
    logic              RegWrite;
    logic [REG_AW-1:0] Rd_addr;
    logic [DATA_W-1:0] Rd_data;
    logic              fwd_valid;
    logic [DATA_W-1:0] instr_retired;

    // Pipeline / testbench side.
    modport master (
        output stall, flush, in_valid, in_reg_write, in_rd_addr, in_wb_sel,
               in_alu_result, in_mem_rdata, in_link_addr, in_load_type,
        input  RegWrite, Rd_addr, Rd_data, fwd_valid, instr_retired
    );

    // Writeback stage side.
    modport slave (
        input  stall, flush, in_valid, in_reg_write, in_rd_addr, in_wb_sel,
               in_alu_result, in_mem_rdata, in_link_addr, in_load_type,
        output RegWrite, Rd_addr, Rd_data, fwd_valid, instr_retired
    );

endinterface

// File: rtl/mips_load_extract.sv
// Big-endian sub-word load extraction: picks the addressed byte or
// halfword from the raw memory word and sign- or zero-extends it.
module mips_load_extract
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        off,
    input  logic [2:0]        load_type,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Byte lane select: offset 0 is the most significant byte.
    always_comb begin
        byte_s = 8'd0;
        case (off)
            2'd0:    byte_s = rdata[31:24];
            2'd1:    byte_s = rdata[23:16];
            2'd2:    byte_s = rdata[15:8];
            2'd3:    byte_s = rdata[7:0];
            default: byte_s = rdata[7:0];
        endcase
    end

    // Halfword select: off[0] is ignored for halfword loads.
    always_comb begin
        half_s = 16'd0;
        if (off[1] == 1'b0) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extension by load type; unknown types pass the whole word.
    always_comb begin
        data = rdata;
        case (load_type)
            LD_H:    data = {{16{half_s[15]}}, half_s};
            LD_HU:   data = {16'd0, half_s};
            LD_B:    data = {{24{byte_s[7]}}, byte_s};
            LD_BU:   data = {24'd0, byte_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mips_writeback_stage.sv
// MEM/WB pipeline register and writeback stage. Selects the writeback
// value ahead of the register, drives the register-file write port and
// forwarding source from flops, and counts retired instructions.
// Optional feature macro: WB_SUBWORD_LOAD_EN (sub-word load extraction).
module mips_writeback_stage
    import mips_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    mips_writeback_stage_if.slave wb
);

    logic [DATA_W-1:0] load_data_s;
    logic [DATA_W-1:0] wdata_s;
    logic              write_qual_s;
    wb_stage_t         stage_r;
    logic [DATA_W-1:0] retired_r;

`ifdef WB_SUBWORD_LOAD_EN
    mips_load_extract u_load_extract (
        .rdata     (wb.in_mem_rdata),
        .off       (wb.in_alu_result[1:0]),
        .load_type (wb.in_load_type),
        .data      (load_data_s)
    );
`else
    logic unused_load_type_s;
    assign unused_load_type_s = ^wb.in_load_type;
    assign load_data_s        = wb.in_mem_rdata;
`endif

    // Writeback source mux; the reserved select code falls back to ALU.
    always_comb begin
        wdata_s = wb.in_alu_result;
        case (wb.in_wb_sel)
            WB_SEL_ALU:  wdata_s = wb.in_alu_result;
            WB_SEL_LOAD: wdata_s = load_data_s;
            WB_SEL_LINK: wdata_s = wb.in_link_addr;
            default:     wdata_s = wb.in_alu_result;
        endcase
    end

    // Writes to $0 are dropped before they reach the stage register.
    assign write_qual_s = wb.in_valid & wb.in_reg_write & (wb.in_rd_addr != 5'd0);

    // Stage register: flush makes a bubble even when stalled, stall holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_r <= WB_STAGE_RESET;
        end else if (wb.flush) begin
            stage_r.valid     <= 1'b0;
            stage_r.reg_write <= 1'b0;
        end else if (wb.stall) begin
            stage_r <= stage_r;
        end else begin
            stage_r.valid     <= wb.in_valid;
            stage_r.reg_write <= write_qual_s;
            stage_r.rd_addr   <= wb.in_rd_addr;
            stage_r.wdata     <= wdata_s;
        end
    end

    // Retire counter: an instruction retires when it leaves an unstalled stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_r <= 32'd0;
        end else if (stage_r.valid && !wb.stall) begin
            retired_r <= retired_r + 32'd1;
        end else begin
            retired_r <= retired_r;
        end
    end

    assign wb.RegWrite      = stage_r.reg_write;
    assign wb.fwd_valid     = stage_r.reg_write;
    assign wb.Rd_addr       = stage_r.rd_addr;
    assign wb.Rd_data       = stage_r.wdata;
    assign wb.instr_retired = retired_r;

endmodule

// File: tb/tb_mips_writeback_stage.sv
// Scoreboard bench for mips_writeback_stage: the driver pushes the
// hand-computed post-edge outputs for each vector, the monitor pops and
// compares one entry after every rising edge.
module tb_mips_writeback_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mips_writeback_stage_if bus ();

    mips_writeback_stage dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] cnt;
        string       name;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

`ifdef WB_SUBWORD_LOAD_EN
    localparam logic [31:0] E_LB1  = 32'hFFFFFFFF;
    localparam logic [31:0] E_LBU1 = 32'h000000FF;
    localparam logic [31:0] E_LH2  = 32'h00007F01;
    localparam logic [31:0] E_LHU0 = 32'h000080FF;
    localparam logic [31:0] E_LB3  = 32'h00000001;
    localparam logic [31:0] E_LH0  = 32'hFFFF80FF;
`else
    localparam logic [31:0] E_LB1  = 32'h80FF7F01;
    localparam logic [31:0] E_LBU1 = 32'h80FF7F01;
    localparam logic [31:0] E_LH2  = 32'h80FF7F01;
    localparam logic [31:0] E_LHU0 = 32'h80FF7F01;
    localparam logic [31:0] E_LB3  = 32'h80FF7F01;
    localparam logic [31:0] E_LH0  = 32'h80FF7F01;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one vector at a falling edge and queue the expected outputs
    // seen after the following rising edge.
    task automatic issue(input string name, input logic st, input logic fl,
                         input logic v, input logic rw, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [2:0] lt,
                         input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] link,
                         input logic erw, input logic [4:0] erd,
                         input logic [31:0] edata, input logic [31:0] ecnt);
        exp_t e;
        bus.stall         = st;
        bus.flush         = fl;
        bus.in_valid      = v;
        bus.in_reg_write  = rw;
        bus.in_rd_addr    = rd;
        bus.in_wb_sel     = sel;
        bus.in_load_type  = lt;
        bus.in_alu_result = alu;
        bus.in_mem_rdata  = rdata;
        bus.in_link_addr  = link;
        e.rw = erw; e.rd = erd; e.data = edata; e.cnt = ecnt; e.name = name;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compare one queued expectation just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.name, "_regwrite"}, {31'd0, bus.RegWrite}, {31'd0, e.rw});
                chk({e.name, "_fwd"}, {31'd0, bus.fwd_valid}, {31'd0, e.rw});
                chk({e.name, "_rd"}, {27'd0, bus.Rd_addr}, {27'd0, e.rd});
                chk({e.name, "_data"}, bus.Rd_data, e.data);
                chk({e.name, "_cnt"}, bus.instr_retired, e.cnt);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0;
        bus.in_reg_write = 1'b0; bus.in_rd_addr = 5'd0; bus.in_wb_sel = 2'b00;
        bus.in_load_type = 3'b000; bus.in_alu_result = 32'd0;
        bus.in_mem_rdata = 32'd0; bus.in_link_addr = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        chk("reset_data", bus.Rd_data, 32'd0);
        chk("reset_cnt", bus.instr_retired, 32'd0);
        rst = 1'b0;

        //     name     st    fl    v     rw    rd     sel    lt      alu            rdata          link           erw   erd    edata          ecnt
        issue("alu",    1'b0, 1'b0, 1'b1, 1'b1, 5'd5,  2'b00, 3'b000, 32'h12345678, 32'h0,        32'h0,         1'b1, 5'd5,  32'h12345678, 32'd0);
        issue("zero",   1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  2'b00, 3'b000, 32'hFFFFFFFF, 32'h0,        32'h0,         1'b0, 5'd0,  32'hFFFFFFFF, 32'd1);
        issue("lb1",    1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  2'b01, 3'b011, 32'h00000001, 32'h80FF7F01, 32'h0,         1'b1, 5'd7,  E_LB1,        32'd2);
        issue("lbu1",   1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  2'b01, 3'b100, 32'h00000001, 32'h80FF7F01, 32'h0,         1'b1, 5'd7,  E_LBU1,       32'd3);
        issue("lh2",    1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  2'b01, 3'b001, 32'h00000002, 32'h80FF7F01, 32'h0,         1'b1, 5'd7,  E_LH2,        32'd4);
        issue("lhu0",   1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  2'b01, 3'b010, 32'h00000000, 32'h80FF7F01, 32'h0,         1'b1, 5'd7,  E_LHU0,       32'd5);
        issue("lb3",    1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  2'b01, 3'b011, 32'h00000003, 32'h80FF7F01, 32'h0,         1'b1, 5'd7,  E_LB3,        32'd6);
        issue("lh0",    1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  2'b01, 3'b001, 32'h00000000, 32'h80FF7F01, 32'h0,         1'b1, 5'd7,  E_LH0,        32'd7);
        issue("link",   1'b0, 1'b0, 1'b1, 1'b1, 5'd31, 2'b10, 3'b000, 32'hDEADBEEF, 32'h0,        32'h00400008,  1'b1, 5'd31, 32'h00400008, 32'd8);
        issue("stall1", 1'b1, 1'b0, 1'b1, 1'b1, 5'd9,  2'b11, 3'b000, 32'h11111111, 32'h0,        32'h0,         1'b1, 5'd31, 32'h00400008, 32'd8);
        issue("stall2", 1'b1, 1'b0, 1'b1, 1'b1, 5'd9,  2'b11, 3'b000, 32'h11111111, 32'h0,        32'h0,         1'b1, 5'd31, 32'h00400008, 32'd8);
        issue("stall3", 1'b1, 1'b0, 1'b1, 1'b1, 5'd9,  2'b11, 3'b000, 32'h11111111, 32'h0,        32'h0,         1'b1, 5'd31, 32'h00400008, 32'd8);
        issue("resv",   1'b0, 1'b0, 1'b1, 1'b1, 5'd9,  2'b11, 3'b000, 32'h11111111, 32'h0,        32'h0,         1'b1, 5'd9,  32'h11111111, 32'd9);
        issue("fl_st",  1'b1, 1'b1, 1'b1, 1'b1, 5'd10, 2'b00, 3'b000, 32'h22222222, 32'h0,        32'h0,         1'b0, 5'd9,  32'h11111111, 32'd9);
        issue("idle",   1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  2'b00, 3'b000, 32'h00000000, 32'h0,        32'h0,         1'b0, 5'd0,  32'h00000000, 32'd9);
        issue("flush",  1'b0, 1'b1, 1'b1, 1'b1, 5'd12, 2'b00, 3'b000, 32'h0000AAAA, 32'h0,        32'h0,         1'b0, 5'd0,  32'h00000000, 32'd9);

        force dut.retired_r = 32'hFFFFFFFE;
        #1;
        release dut.retired_r;

        issue("wrap1",  1'b0, 1'b0, 1'b1, 1'b1, 5'd3,  2'b00, 3'b000, 32'h00000003, 32'h0,        32'h0,         1'b1, 5'd3,  32'h00000003, 32'hFFFFFFFE);
        issue("wrap2",  1'b0, 1'b0, 1'b1, 1'b1, 5'd4,  2'b00, 3'b000, 32'h00000004, 32'h0,        32'h0,         1'b1, 5'd4,  32'h00000004, 32'hFFFFFFFF);
        issue("wrap3",  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  2'b00, 3'b000, 32'h00000000, 32'h0,        32'h0,         1'b0, 5'd0,  32'h00000000, 32'h00000000);
        issue("lw1",    1'b0, 1'b0, 1'b1, 1'b1, 5'd6,  2'b01, 3'b000, 32'h00000100, 32'hCAFEF00D, 32'h0,         1'b1, 5'd6,  32'hCAFEF00D, 32'd0);
        issue("lw2",    1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  2'b01, 3'b000, 32'h00000000, 32'h01020304, 32'h0,         1'b1, 5'd8,  32'h01020304, 32'd1);

        // Another lw is in flight when reset hits between edges.
        bus.in_rd_addr   = 5'd9;
        bus.in_mem_rdata = 32'h55AA55AA;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        chk("midrst_fwd", {31'd0, bus.fwd_valid}, 32'd0);
        chk("midrst_rd", {27'd0, bus.Rd_addr}, 32'd0);
        chk("midrst_data", bus.Rd_data, 32'd0);
        chk("midrst_cnt", bus.instr_retired, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        issue("post_rst", 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 2'b00, 3'b000, 32'h00000002, 32'h0,      32'h0,         1'b1, 5'd2,  32'h00000002, 32'd0);
        issue("post_idle",1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h00000000, 32'h0,      32'h0,         1'b0, 5'd0,  32'h00000000, 32'd1);

        @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
